// File: rtl/keypad_input_core.sv
// rtl/keypad_input_core.sv - 4x4 keypad scan, debounce and BCD entry buffer
// Optional build macro: KEYPAD_MULTIKEY_REJECT_EN (multi-key rounds read as no key).
module keypad_input_core #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_ROUNDS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_in,
  input  logic        entry_en,
  input  logic        clr_entry,
  output logic [3:0]  col_out,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] input_data,
  output logic [2:0]  digit_count,
  output logic        enter_pulse,
  output logic [15:0] entered_code,
  output logic        code_full
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_ROUNDS + 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PRESS_DB = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_REL_DB   = 2'd3;

  logic [SW-1:0] slot_cnt;
  logic [1:0]    col_idx;
  logic [3:0]    row_s1, row_s2;
  logic [15:0]   map_q, full_map;
  logic          slot_end, round_end, multi, present;
  logic [3:0]    low_idx, rnd_code;
  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    cand, cand_n;
  logic          fire;

  function automatic logic [3:0] map_code(input logic [3:0] idx);
    case (idx)
      4'd0:  map_code = 4'h1;
      4'd1:  map_code = 4'h2;
      4'd2:  map_code = 4'h3;
      4'd3:  map_code = 4'hA;
      4'd4:  map_code = 4'h4;
      4'd5:  map_code = 4'h5;
      4'd6:  map_code = 4'h6;
      4'd7:  map_code = 4'hB;
      4'd8:  map_code = 4'h7;
      4'd9:  map_code = 4'h8;
      4'd10: map_code = 4'h9;
      4'd11: map_code = 4'hC;
      4'd12: map_code = 4'hE;
      4'd13: map_code = 4'h0;
      4'd14: map_code = 4'hF;
      default: map_code = 4'hD;
    endcase
  endfunction

  assign col_out   = ~(4'b0001 << col_idx);
  assign slot_end  = (slot_cnt == SW'(SCAN_DIV - 1));
  assign round_end = slot_end && (col_idx == 2'd3);

  // Pressed map indexed row*4+col; col3 bits come straight from the synchronizer on the round's last sample.
  always_comb begin
    full_map = map_q;
    for (int r = 0; r < 4; r++) full_map[r*4+3] = ~row_s2[r];
    low_idx = 4'd0;
    for (int i = 15; i >= 0; i--) if (full_map[i]) low_idx = 4'(i);
    multi = (full_map & (full_map - 16'd1)) != 16'd0;
`ifdef KEYPAD_MULTIKEY_REJECT_EN
    present = (full_map != 16'd0) && !multi;
`else
    present = (full_map != 16'd0);
`endif
    rnd_code = map_code(low_idx);
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    fire    = 1'b0;
    if (round_end) begin
      case (state)
        ST_IDLE: if (present) begin
          cand_n = rnd_code;
          cnt_n  = CW'(1);
          if (DEBOUNCE_ROUNDS == 1) begin
            state_n = ST_HELD;
            fire    = 1'b1;
          end else begin
            state_n = ST_PRESS_DB;
          end
        end
        ST_PRESS_DB: begin
          if (!present) begin
            state_n = ST_IDLE;
          end else if (rnd_code == cand) begin
            cnt_n = cnt + 1'b1;
            if (cnt_n >= CW'(DEBOUNCE_ROUNDS)) begin
              state_n = ST_HELD;
              fire    = 1'b1;
            end
          end else begin
            cand_n = rnd_code;
            cnt_n  = CW'(1);
          end
        end
        ST_HELD: if (!present) begin
          cnt_n   = CW'(1);
          state_n = (DEBOUNCE_ROUNDS == 1) ? ST_IDLE : ST_REL_DB;
        end
        default: begin
          if (present) begin
            state_n = ST_HELD;
          end else begin
            cnt_n = cnt + 1'b1;
            if (cnt_n >= CW'(DEBOUNCE_ROUNDS)) state_n = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt <= '0;
      col_idx  <= 2'd0;
      row_s1   <= 4'hF;
      row_s2   <= 4'hF;
      map_q    <= '0;
      state    <= ST_IDLE;
      cnt      <= '0;
      cand     <= 4'h0;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
      state  <= state_n;
      cnt    <= cnt_n;
      cand   <= cand_n;
      if (slot_end) begin
        slot_cnt <= '0;
        col_idx  <= col_idx + 2'd1;
        for (int r = 0; r < 4; r++) map_q[{2'(r), col_idx}] <= ~row_s2[r];
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

  // clr_entry wins over any key action landing on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_valid    <= 1'b0;
      key_code     <= 4'h0;
      input_data   <= 16'hFFFF;
      digit_count  <= 3'd0;
      enter_pulse  <= 1'b0;
      entered_code <= 16'hFFFF;
      code_full    <= 1'b0;
    end else begin
      key_valid   <= fire;
      enter_pulse <= 1'b0;
      if (fire) key_code <= cand_n;
      if (clr_entry) begin
        input_data  <= 16'hFFFF;
        digit_count <= 3'd0;
      end else if (fire && entry_en) begin
        if (cand_n <= 4'h9) begin
          if (digit_count < 3'd4) begin
            input_data  <= {input_data[11:0], cand_n};
            digit_count <= digit_count + 3'd1;
          end
        end else if (cand_n == 4'hE) begin
          input_data  <= 16'hFFFF;
          digit_count <= 3'd0;
        end else if (cand_n == 4'hF) begin
          enter_pulse  <= 1'b1;
          entered_code <= input_data;
          code_full    <= (digit_count == 3'd4);
          input_data   <= 16'hFFFF;
          digit_count  <= 3'd0;
        end
      end
    end
  end

endmodule
